noc_sequencer: RTL

Global phase controller for the NoC router array. It drives the shared `op`, `data` and `in_cycle` buses that every router samples on the falling edge of `clk`. It configures the routers with one `Init` and a stream of `LoadRt` entries. It then steps each network cycle through `LoadStaging` → `Phase0` → `Phase1` until the network drains or a cycle limit is hit. It sits at top level beside the router instances and the traffic source, and is the only writer of `op`.

---
 rtl/noc_sequencer_if.sv | 44 ++++
 rtl/noc_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_sequencer_if.sv
// Purpose: bundles the sequencer's control-side handshake and the shared router op/data/in_cycle broadcast bus.
// Latency: pure wiring, no storage.
// Backpressure: the routing-entry stream is acknowledged on rt_ready; the other signals are level-sampled.
`ifndef OP_SIZE
`define OP_SIZE 3
`endif
`ifndef IN_CYCLE_SIZE
`define IN_CYCLE_SIZE 16
`endif
`ifndef DataBitSize
`define DataBitSize 32
`endif

interface noc_sequencer_if;
    logic                       start;
    logic [31:0]                credit_delay;
    logic                       rt_valid;
    logic [31:0]                rt_data;
    logic                       rt_last;
    logic                       rt_ready;
    logic                       all_done;
    logic                       pending;
    logic [`IN_CYCLE_SIZE-1:0]  max_cycle;
    logic [`OP_SIZE-1:0]        op;
    logic [`DataBitSize-1:0]    data;
    logic [`IN_CYCLE_SIZE-1:0]  in_cycle;
    logic                       busy;
    logic                       finished;
    logic                       timeout;

    // Sequencer side: consumes run control and router status, drives the broadcast bus.
    modport master (
        input  start, credit_delay, rt_valid, rt_data, rt_last,
               all_done, pending, max_cycle,
        output rt_ready, op, data, in_cycle, busy, finished, timeout
    );

    // Environment side: traffic source, routing-table feeder and routers.
    modport slave (
        output start, credit_delay, rt_valid, rt_data, rt_last,
               all_done, pending, max_cycle,
        input  rt_ready, op, data, in_cycle, busy, finished, timeout
    );
endinterface

// File: rtl/noc_sequencer.sv
// Purpose: global phase controller for the router array (Init, LoadRt stream, then STG/PH0/PH1 per network cycle); optional cycle-limit stop under macro NOC_SEQ_TIMEOUT_EN.
// Latency: all outputs registered; start to op=Init is 1 clock, one network cycle is 3 clocks.
// Backpressure: a routing entry is sampled on each edge entering a LOAD_RT clock (rt_valid low gives a NOP wait clock); rt_ready acknowledges the entry shown that clock; no timeout while waiting.
`ifndef OP_SIZE
`define OP_SIZE 3
`endif
`ifndef IN_CYCLE_SIZE
`define IN_CYCLE_SIZE 16
`endif
`ifndef DataBitSize
`define DataBitSize 32
`endif
`ifndef NOP
`define NOP 3'd0
`endif
`ifndef Init
`define Init 3'd1
`endif
`ifndef LoadRt
`define LoadRt 3'd2
`endif
`ifndef LoadStaging
`define LoadStaging 3'd3
`endif
`ifndef Phase0
`define Phase0 3'd4
`endif
`ifndef Phase1
`define Phase1 3'd5
`endif

module noc_sequencer #(
    parameter int DRAIN_CYCLES = 2          // legal range 1..15 (4-bit drain counter)
) (
    input  logic              clk,
    input  logic              rst,
    noc_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD_RT,
        S_STG,
        S_PH0,
        S_PH1,
        S_FINISH
    } state_t;

    localparam logic [3:0] DRAIN_LIM = 4'(DRAIN_CYCLES);

    state_t                     state_q, state_d;
    logic [`OP_SIZE-1:0]        op_q, op_d;
    logic [`DataBitSize-1:0]    data_q, data_d;
    logic [`IN_CYCLE_SIZE-1:0]  in_cycle_q, in_cycle_d;
    logic [3:0]                 drain_q, drain_d;
    logic                       rt_ready_q, rt_ready_d;
    logic                       last_q, last_d;
    logic                       busy_q, busy_d;
    logic                       finished_q, finished_d;
    logic                       timeout_q, timeout_d;

    logic                       accept;
    logic [3:0]                 drain_step;
    logic                       drain_hit;
    logic                       limit_hit;

    // An entry is taken on the edge leaving INIT or leaving a LOAD_RT clock that
    // is not already showing the final entry; it is then broadcast for one clock.
    assign accept = bus.rt_valid &&
                    ((state_q == S_INIT) || ((state_q == S_LOAD_RT) && !last_q));

    // Drain progress as it would stand after the PH1 clock currently on the bus.
    assign drain_step = (bus.all_done && !bus.pending) ? (drain_q + 4'd1) : 4'd0;
    assign drain_hit  = (drain_step == DRAIN_LIM);

`ifdef NOC_SEQ_TIMEOUT_EN
    assign limit_hit = (in_cycle_q == bus.max_cycle);
`else
    // Runs end only by drain; the limit input is intentionally left unobserved.
    logic unused_max_cycle;
    assign unused_max_cycle = ^bus.max_cycle;
    assign limit_hit        = 1'b0;
`endif

    // Next state, run bookkeeping, and the registered image of the next clock's outputs.
    always_comb begin
        state_d    = state_q;
        in_cycle_d = in_cycle_q;
        drain_d    = drain_q;
        last_d     = last_q;
        timeout_d  = timeout_q;
        op_d       = `NOP;
        data_d     = '0;
        rt_ready_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_INIT;
                    in_cycle_d = '0;
                    drain_d    = '0;
                    last_d     = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            S_INIT: begin
                state_d = S_LOAD_RT;
            end
            S_LOAD_RT: begin
                // The clock that broadcast the final entry hands over to staging.
                if (last_q) begin
                    state_d = S_STG;
                end
            end
            S_STG: begin
                state_d = S_PH0;
            end
            S_PH0: begin
                state_d = S_PH1;
            end
            S_PH1: begin
                // all_done/pending are only meaningful here, after the routers' Phase1.
                drain_d = drain_step;
                if (drain_hit) begin
                    state_d = S_FINISH;
                end else if (limit_hit) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
                end else begin
                    state_d    = S_STG;
                    in_cycle_d = in_cycle_q + 1'b1;
                end
            end
            S_FINISH: begin
                if (bus.start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            last_d = bus.rt_last;
        end

        case (state_d)
            S_INIT: begin
                op_d   = `Init;
                data_d = bus.credit_delay;
            end
            S_LOAD_RT: begin
                if (accept) begin
                    op_d       = `LoadRt;
                    data_d     = bus.rt_data;
                    rt_ready_d = 1'b1;
                end
            end
            S_STG:   op_d = `LoadStaging;
            S_PH0:   op_d = `Phase0;
            S_PH1:   op_d = `Phase1;
            default: op_d = `NOP;
        endcase

        busy_d     = (state_d != S_IDLE) && (state_d != S_FINISH);
        finished_d = (state_d == S_FINISH);
    end

    // State and output registers; reset aborts any run but leaves router state alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= `NOP;
            data_q     <= '0;
            in_cycle_q <= '0;
            drain_q    <= '0;
            rt_ready_q <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            in_cycle_q <= in_cycle_d;
            drain_q    <= drain_d;
            rt_ready_q <= rt_ready_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.op       = op_q;
    assign bus.data     = data_q;
    assign bus.in_cycle = in_cycle_q;
    assign bus.rt_ready = rt_ready_q;
    assign bus.busy     = busy_q;
    assign bus.finished = finished_q;
    assign bus.timeout  = timeout_q;

endmodule
